// File: rtl/power_check_pkg.sv
// Shared types and defaults for the ADC conversion scheduler.
package power_check_pkg;

  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_START,
    ST_WAIT
  } sched_state_e;

endpackage

// File: rtl/sched_timer.sv
// Loadable CNT_W counter with terminal-count flag; counts down to zero or up to tc_val.
module sched_timer
  import power_check_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter bit          COUNT_DOWN = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic [CNT_W-1:0] tc_val,
  output logic             tc
);

  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = COUNT_DOWN ? count_q - CNT_W'(1) : count_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Up mode uses >= so a shortened period mid-count still terminates promptly.
  assign tc = COUNT_DOWN ? (count_q == '0) : (count_q >= tc_val);

endmodule

// File: rtl/adc_conv_scheduler.sv
// ADC conversion scheduler: laser-synchronised peak samples plus optional background CW samples.
// Build macro CW_SAMPLE_EN enables the CW timer; without it only peak samples are scheduled.
module adc_conv_scheduler
  import power_check_pkg::*;
#(
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             laser_pulse,
  input  logic [CNT_W-1:0] pulse_delay,
  input  logic [CNT_W-1:0] cw_period,
  input  logic             clear_status,
  input  logic             conv_done,
  output logic             conv_start,
  output logic             sample_valid,
  output logic             sample_is_peak,
  output logic             busy,
  output logic             missed_pulse,
  output logic             timeout_fail
);

  sched_state_e     state_q, state_d;
  logic             laser_q, laser_d, arm_q, arm_d;
  logic             peak_pend_q, peak_pend_d;
  logic             tag_q, tag_d;
  logic             valid_q, valid_d;
  logic             missed_q, missed_d;
  logic             timeout_q, timeout_d;
  logic             laser_rise, peak_busy, cw_req, cw_grant;
  logic             tmr_load, tmr_en, tmr_tc;
  logic [CNT_W-1:0] tmr_load_val;

  // arm_q masks the first cycle after reset so a laser held high is not seen as an edge.
  assign laser_rise = laser_pulse & ~laser_q & arm_q;
  assign peak_busy  = peak_pend_q | (state_q == ST_DELAY) |
                      (((state_q == ST_START) | (state_q == ST_WAIT)) & tag_q);
  assign cw_grant   = (state_q == ST_IDLE) & ~peak_pend_q & cw_req;

  sched_timer #(.CNT_W(CNT_W), .COUNT_DOWN(1'b1)) u_delay_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .tc_val   ('0),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d      = state_q;
    laser_d      = laser_pulse;
    arm_d        = 1'b1;
    peak_pend_d  = peak_pend_q | (laser_rise & ~peak_busy);
    tag_d        = tag_q;
    valid_d      = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_en       = 1'b0;
    missed_d     = clear_status ? 1'b0 : missed_q;
    timeout_d    = clear_status ? 1'b0 : timeout_q;
    if (laser_rise & peak_busy) missed_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (peak_pend_q) begin
          state_d      = ST_DELAY;
          peak_pend_d  = 1'b0;
          tag_d        = 1'b1;
          tmr_load     = 1'b1;
          // Load delay-1 so DELAY lasts pulse_delay cycles, and at least one.
          tmr_load_val = (pulse_delay == '0) ? '0 : pulse_delay - CNT_W'(1);
        end else if (cw_grant) begin
          state_d = ST_START;
          tag_d   = 1'b0;
        end
      end
      ST_DELAY: begin
        if (tmr_tc) state_d = ST_START;
        else        tmr_en  = 1'b1;
      end
      ST_START: begin
        state_d      = ST_WAIT;
        tmr_load     = 1'b1;
        tmr_load_val = CNT_W'(TIMEOUT_CYCLES - 1);
      end
      ST_WAIT: begin
        if (conv_done) begin
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end else if (tmr_tc) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      laser_q     <= 1'b0;
      arm_q       <= 1'b0;
      peak_pend_q <= 1'b0;
      tag_q       <= 1'b0;
      valid_q     <= 1'b0;
      missed_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      laser_q     <= laser_d;
      arm_q       <= arm_d;
      peak_pend_q <= peak_pend_d;
      tag_q       <= tag_d;
      valid_q     <= valid_d;
      missed_q    <= missed_d;
      timeout_q   <= timeout_d;
    end
  end

`ifdef CW_SAMPLE_EN
  logic cw_pend_q, cw_pend_d, cw_tc, cw_hit, cw_off;

  assign cw_off = (cw_period == '0);
  assign cw_hit = cw_tc & ~cw_off;

  sched_timer #(.CNT_W(CNT_W), .COUNT_DOWN(1'b0)) u_cw_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (cw_off | cw_hit),
    .load_val ('0),
    .en       (1'b1),
    .tc_val   (cw_period - CNT_W'(1)),
    .tc       (cw_tc)
  );

  always_comb begin
    cw_pend_d = cw_pend_q;
    if (cw_grant) cw_pend_d = 1'b0;
    if (cw_hit)   cw_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cw_pend_q <= 1'b0;
    else       cw_pend_q <= cw_pend_d;
  end

  assign cw_req         = cw_pend_q;
  assign sample_is_peak = tag_q;
`else
  logic unused_cw;
  assign unused_cw      = ^cw_period;
  assign cw_req         = 1'b0;
  assign sample_is_peak = 1'b1;
`endif

  assign conv_start   = (state_q == ST_START);
  assign busy         = (state_q != ST_IDLE);
  assign sample_valid = valid_q;
  assign missed_pulse = missed_q;
  assign timeout_fail = timeout_q;

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Self-checking bench for adc_conv_scheduler; CW scenarios compile only with CW_SAMPLE_EN.
module tb_adc_conv_scheduler;

  localparam int CNT_W = 16;
  localparam int TMO   = 255;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             laser_pulse = 1'b0;
  logic             clear_status = 1'b0;
  logic             conv_done = 1'b0;
  logic [CNT_W-1:0] pulse_delay = '0;
  logic [CNT_W-1:0] cw_period = '0;
  logic             conv_start, sample_valid, sample_is_peak, busy, missed_pulse, timeout_fail;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  adc_conv_scheduler #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .laser_pulse    (laser_pulse),
    .pulse_delay    (pulse_delay),
    .cw_period      (cw_period),
    .clear_status   (clear_status),
    .conv_done      (conv_done),
    .conv_start     (conv_start),
    .sample_valid   (sample_valid),
    .sample_is_peak (sample_is_peak),
    .busy           (busy),
    .missed_pulse   (missed_pulse),
    .timeout_fail   (timeout_fail)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Peak model: laser edge in cycle t0, one IDLE cycle, DELAY of max(pd,1) cycles, then START.
  function automatic int peak_start_cycle(input int t0, input int pd);
    return t0 + 2 + ((pd == 0) ? 1 : pd);
  endfunction

  // Waits for conv_start; returns its cycle (or -1) and leaves the caller in the following cycle.
  task automatic wait_start(input int budget, output int at, output int n_sv);
    at   = -1;
    n_sv = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sample_valid) n_sv++;
      if (conv_start) begin
        at = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (at >= 0) step();
  endtask

  // Called in the first WAIT cycle; conv_done lands lat cycles later; ends in the sample_valid cycle.
  task automatic respond(input int lat);
    repeat (lat) step();
    conv_done = 1'b1;
    step();
    conv_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic exp_tag;
`ifdef CW_SAMPLE_EN
    exp_tag = 1'b0;
`else
    exp_tag = 1'b1;
`endif
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({conv_start, sample_valid, busy, missed_pulse, timeout_fail} !== 5'b0)
      $display("FAIL reset_outputs: got %b expected 00000",
               {conv_start, sample_valid, busy, missed_pulse, timeout_fail});
    else n_pass++;
    n_checks++;
    if (sample_is_peak !== exp_tag)
      $display("FAIL reset_tag: got %b expected %b", sample_is_peak, exp_tag);
    else n_pass++;
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) step();
  endtask

  task automatic run_peak(input int pd, input int lat);
    int t0, at, nsv, exp_at;
    pulse_delay = CNT_W'(pd);
    t0 = cyc;
    laser_pulse = 1'b1;
    step();
    laser_pulse = 1'b0;
    conv_done   = 1'b1;           // stray conv_done while IDLE must be ignored
    step();
    conv_done   = 1'b0;
    pulse_delay = CNT_W'($urandom_range(0, 60));  // change after DELAY entry takes no effect
    wait_start(pd + 40, at, nsv);
    exp_at = peak_start_cycle(t0, pd);
    n_checks++;
    if (at != exp_at) $display("FAIL peak_start pd=%0d: got cycle %0d expected %0d", pd, at - t0, exp_at - t0);
    else n_pass++;
    n_checks++;
    if (nsv != 0) $display("FAIL peak_early_valid pd=%0d: got %0d expected 0", pd, nsv);
    else n_pass++;
    if (at >= 0) begin
      respond(lat);
      n_checks++;
      if (sample_valid !== 1'b1) $display("FAIL peak_valid lat=%0d: got %b expected 1", lat, sample_valid);
      else n_pass++;
      n_checks++;
      if (sample_is_peak !== 1'b1) $display("FAIL peak_tag: got %b expected 1", sample_is_peak);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL peak_idle_after: got busy=%b expected 0", busy);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_peak();
    run_peak(10, 4);
    run_peak(0, 0);
    run_peak(1, 3);
    run_peak(5, TMO - 1);
    for (int i = 0; i < 6; i++) run_peak($urandom_range(0, 30), $urandom_range(0, 20));
  endtask

  task automatic test_missed();
    int t0, at, nsv;
    pulse_delay = CNT_W'(20);
    t0 = cyc;
    laser_pulse = 1'b1;
    step();
    laser_pulse = 1'b0;
    repeat (5) step();
    laser_pulse = 1'b1;
    step();
    laser_pulse = 1'b0;
    @(negedge clk);
    n_checks++;
    if (missed_pulse !== 1'b1) $display("FAIL missed_in_delay: got %b expected 1", missed_pulse);
    else n_pass++;
    step();
    wait_start(60, at, nsv);
    n_checks++;
    if (at != t0 + 22) $display("FAIL missed_start: got cycle %0d expected 22", at - t0);
    else n_pass++;
    laser_pulse  = 1'b1;
    clear_status = 1'b1;
    step();
    laser_pulse  = 1'b0;
    clear_status = 1'b0;
    @(negedge clk);
    n_checks++;
    if (missed_pulse !== 1'b1) $display("FAIL missed_set_wins: got %b expected 1", missed_pulse);
    else n_pass++;
    step();
    respond(2);
    n_checks++;
    if (sample_valid !== 1'b1) $display("FAIL missed_valid: got %b expected 1", sample_valid);
    else n_pass++;
    step();
    wait_start(50, at, nsv);
    n_checks++;
    if (at != -1) $display("FAIL missed_single_start: got extra start at %0d expected none", at - t0);
    else n_pass++;
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    @(negedge clk);
    n_checks++;
    if (missed_pulse !== 1'b0) $display("FAIL missed_clear: got %b expected 0", missed_pulse);
    else n_pass++;
    step();
  endtask

  task automatic test_timeout();
    int t0, at, nsv, nsv_wait;
    pulse_delay = '0;
    t0 = cyc;
    laser_pulse = 1'b1;
    step();
    laser_pulse = 1'b0;
    wait_start(20, at, nsv);
    n_checks++;
    if (at != t0 + 3) $display("FAIL timeout_start: got cycle %0d expected 3", at - t0);
    else n_pass++;
    nsv_wait = 0;
    for (int i = 0; i < TMO - 1; i++) begin
      @(negedge clk);
      if (sample_valid) nsv_wait++;
      step();
    end
    @(negedge clk);
    n_checks++;
    if ({busy, timeout_fail} !== 2'b10)
      $display("FAIL timeout_last_wait: got busy,timeout=%b expected 10", {busy, timeout_fail});
    else n_pass++;
    step();
    @(negedge clk);
    n_checks++;
    if ({busy, timeout_fail, sample_valid} !== 3'b010)
      $display("FAIL timeout_expired: got busy,timeout,valid=%b expected 010",
               {busy, timeout_fail, sample_valid});
    else n_pass++;
    n_checks++;
    if (nsv_wait != 0) $display("FAIL timeout_no_valid: got %0d expected 0", nsv_wait);
    else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    int at, nsv;
    pulse_delay = CNT_W'(3);
    laser_pulse = 1'b1;
    step();
    laser_pulse = 1'b0;
    wait_start(20, at, nsv);
    laser_pulse = 1'b1;
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({conv_start, sample_valid, busy, missed_pulse, timeout_fail} !== 5'b0)
      $display("FAIL reset_mid_outputs: got %b expected 00000",
               {conv_start, sample_valid, busy, missed_pulse, timeout_fail});
    else n_pass++;
    step();
    rstn = 1'b1;
    conv_done = 1'b1;
    step();
    conv_done = 1'b0;
    wait_start(40, at, nsv);
    n_checks++;
    if (at != -1 || nsv != 0)
      $display("FAIL reset_mid_quiet: got start=%0d valid=%0d expected -1 0", at, nsv);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_mid_idle: got busy=%b expected 0", busy);
    else n_pass++;
    laser_pulse = 1'b0;
    step();
  endtask

`ifdef CW_SAMPLE_EN
  task automatic test_cw();
    int at, prev, nsv;
    prev = -1;
    cw_period = CNT_W'(100);
    for (int k = 0; k < 3; k++) begin
      wait_start(150, at, nsv);
      if (prev >= 0) begin
        n_checks++;
        if (at - prev != 100) $display("FAIL cw_spacing: got %0d expected 100", at - prev);
        else n_pass++;
      end
      prev = at;
      respond(1);
      n_checks++;
      if ({sample_valid, sample_is_peak} !== 2'b10)
        $display("FAIL cw_tag: got valid,peak=%b expected 10", {sample_valid, sample_is_peak});
      else n_pass++;
      step();
    end
  endtask

  task automatic test_priority();
    int at, nsv, w;
    pulse_delay = CNT_W'(7);
    cw_period   = CNT_W'(5);
    wait_start(20, at, nsv);
    laser_pulse = 1'b1;
    step();
    laser_pulse = 1'b0;
    repeat (8) step();
    w = cyc;
    respond(0);
    n_checks++;
    if ({sample_valid, sample_is_peak} !== 2'b10)
      $display("FAIL prio_first_cw: got valid,peak=%b expected 10", {sample_valid, sample_is_peak});
    else n_pass++;
    step();
    wait_start(40, at, nsv);
    n_checks++;
    if (at != peak_start_cycle(w, 7)) $display("FAIL prio_peak_start: got %0d expected %0d", at - w, 9);
    else n_pass++;
    respond(0);
    n_checks++;
    if ({sample_valid, sample_is_peak} !== 2'b11)
      $display("FAIL prio_peak_tag: got valid,peak=%b expected 11", {sample_valid, sample_is_peak});
    else n_pass++;
    step();
    wait_start(20, at, nsv);
    respond(0);
    n_checks++;
    if ({sample_valid, sample_is_peak} !== 2'b10)
      $display("FAIL prio_cw_next: got valid,peak=%b expected 10", {sample_valid, sample_is_peak});
    else n_pass++;
    step();
    cw_period = '0;
    conv_done = 1'b1;
    repeat (30) step();
    conv_done = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_peak();
    test_missed();
    test_timeout();
    test_reset_mid();
`ifdef CW_SAMPLE_EN
    test_cw();
    test_priority();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
